// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - ALU result FIFO, FWFT read, sticky overflow; optional clamp via ALU_RESULT_SAT_EN
module alu_result_fifo #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] res_i,
  input  logic              valid_i,
  input  logic              rd_ready_i,
  input  logic              clr_ovf_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] wr_data;

  assign empty_o    = (count == '0);
  assign full_o     = (count == FULL_CNT);
  assign count_o    = count;
  assign rd_valid_o = !empty_o;
  assign rd_data_o  = empty_o ? '0 : mem[rd_ptr];
  assign overflow_o = ovf;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign pop  = rd_valid_o && rd_ready_i;
  assign push = valid_i && (!full_o || pop);
  assign drop = valid_i && full_o && !pop;

`ifdef ALU_RESULT_SAT_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(127);
  localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-128);

  // Clamp incoming result into the signed 8-bit range before it is stored
  always_comb begin
    wr_data = res_i;
    if ($signed(res_i) > SAT_MAX) begin
      wr_data = SAT_MAX;
    end else if ($signed(res_i) < SAT_MIN) begin
      wr_data = SAT_MIN;
    end
  end
`else
  assign wr_data = res_i;
`endif

  // Storage write; the array itself is never cleared
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf_i) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - self-checking bench for alu_result_fifo against a queue model
module tb_alu_result_fifo;

  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] res_i;
  logic          valid_i;
  logic          rd_ready_i;
  logic          clr_ovf_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic [AW:0]   count_o;
  logic          full_o;
  logic          empty_o;
  logic          overflow_o;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic          ovf_m;

  alu_result_fifo #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .res_i      (res_i),
    .valid_i    (valid_i),
    .rd_ready_i (rd_ready_i),
    .clr_ovf_i  (clr_ovf_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] stored_value(logic [DW-1:0] d);
`ifdef ALU_RESULT_SAT_EN
    int s;
    s = int'($signed(d));
    if (s > 127) return 16'h007F;
    if (s < -128) return 16'hFF80;
    return d;
`else
    return d;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("count", 32'(count_o), 32'(q.size()));
    chk("empty", 32'(empty_o), 32'(q.size() == 0));
    chk("full", 32'(full_o), 32'(q.size() == DEPTH));
    chk("rd_valid", 32'(rd_valid_o), 32'(q.size() != 0));
    chk("rd_data", 32'(rd_data_o), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("overflow", 32'(overflow_o), 32'(ovf_m));
  endtask

  task automatic cyc(logic v, logic [DW-1:0] d, logic r, logic c, logic x);
    bit pop_m;
    bit full_m;
    valid_i    = v;
    res_i      = d;
    rd_ready_i = r;
    clr_ovf_i  = c;
    rst        = x;
    @(posedge clk);
    #1;
    if (x) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      pop_m  = (q.size() != 0) && r;
      full_m = (q.size() == DEPTH);
      if (pop_m) void'(q.pop_front());
      if (v && (!full_m || pop_m)) q.push_back(stored_value(d));
      if (v && full_m && !pop_m) ovf_m = 1'b1;
      else if (c) ovf_m = 1'b0;
    end
    valid_i    = 1'b0;
    rd_ready_i = 1'b0;
    clr_ovf_i  = 1'b0;
    rst        = 1'b0;
    chk_model();
  endtask

  initial begin
    rst = 1'b1; res_i = '0; valid_i = 1'b0; rd_ready_i = 1'b0; clr_ovf_i = 1'b0;
    ovf_m = 1'b0;

    cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_count", 32'(count_o), 32'd0);
    chk("reset_empty", 32'(empty_o), 32'd1);
    chk("reset_rd_data", 32'(rd_data_o), 32'd0);

    cyc(1'b1, 16'hFED4, 1'b0, 1'b0, 1'b0);
    chk("single_data", 32'(rd_data_o), 32'h0000FED4);
    chk("single_valid", 32'(rd_valid_o), 32'd1);
    chk("single_count", 32'(count_o), 32'd1);
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    chk("single_drained", 32'(empty_o), 32'd1);

    for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_count", 32'(count_o), 32'd8);
    cyc(1'b1, 16'd9, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf", 32'(overflow_o), 32'd1);
    chk("drop_count", 32'(count_o), 32'd8);
    cyc(1'b1, 16'd10, 1'b0, 1'b1, 1'b0);
    chk("clr_vs_drop", 32'(overflow_o), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", 32'(rd_data_o), 32'(i));
      cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 32'(empty_o), 32'd1);
    cyc(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    chk("ovf_cleared", 32'(overflow_o), 32'd0);

    for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'd99, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count", 32'(count_o), 32'd8);
    chk("fullpp_ovf", 32'(overflow_o), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      chk("fullpp_order", 32'(rd_data_o), 32'(i));
      cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    end
    chk("fullpp_last", 32'(rd_data_o), 32'd99);
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 16'(100 + i), 1'b1, 1'b0, 1'b0);
      chk("wrap_data", 32'(rd_data_o), 32'(100 + i));
      chk("wrap_count", 32'(count_o), 32'd1);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(200 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count_o), 32'd5);
    cyc(1'b1, 16'd7, 1'b1, 1'b0, 1'b1);
    chk("midreset_count", 32'(count_o), 32'd0);
    chk("midreset_valid", 32'(rd_valid_o), 32'd0);

    cyc(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hFF38, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'd45, 1'b0, 1'b0, 1'b0);
`ifdef ALU_RESULT_SAT_EN
    chk("sat_hi", 32'(rd_data_o), 32'h007F);
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    chk("sat_lo", 32'(rd_data_o), 32'hFF80);
`else
    chk("nosat_hi", 32'(rd_data_o), 32'd200);
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    chk("nosat_lo", 32'(rd_data_o), 32'hFF38);
`endif
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    chk("sat_mid", 32'(rd_data_o), 32'd45);
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      int rd_pct;
      rd_pct = ((i / 100) % 2 == 0) ? 25 : 80;
      cyc(($urandom % 4) != 0, 16'($urandom), ($urandom % 100) < rd_pct,
          ($urandom % 16) == 0, ($urandom % 150) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
